// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong input/menu control path.
package pong_pkg;

  localparam int CLK_HZ = 25_175_000;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_1P   = 2'd1;
  localparam logic [1:0] MODE_2P   = 2'd2;

  typedef enum logic [1:0] {
    ST_ARMING,
    ST_READY,
    ST_PLAY
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// One push-button path: two-flop synchronizer, stability counter and
// debounced level register. Idle level is 1 (active-low buttons).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 251_750,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           r_sync;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 w_synced;

  assign w_synced = r_sync[1];
  assign o_level  = r_level;

  // Bring the asynchronous pin into the clock domain; flops idle at released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_raw};
  end

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the current level restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (w_synced == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_level <= w_synced;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_input_ctrl.sv
// Button conditioning and menu control for the Pong game logic: four
// debounced active-low buttons, a one-cycle start pulse and the mode choice.
module pong_input_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 251_750,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       up_p1_raw,
  input  logic       down_p1_raw,
  input  logic       up_p2_raw,
  input  logic       down_p2_raw,
  input  logic       game_startup,
  input  logic       game_over,
  output logic       up_p1,
  output logic       down_p1,
  output logic       up_p2,
  output logic       down_p2,
  output logic       start_trigger,
  output logic [1:0] mode_choice
);

  localparam int NB = 4;

  // Bit order everywhere: {down_p2, up_p2, down_p1, up_p1}.
  logic [NB-1:0] w_raw, w_lvl, w_press;
  logic [NB-1:0] r_lvl_q;
  logic          w_menu, r_menu_q;
  state_t        r_state;
  logic          r_start;
  logic [1:0]    r_mode;

  assign w_raw = {down_p2_raw, up_p2_raw, down_p1_raw, up_p1_raw};

  for (genvar g = 0; g < NB; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .i_clk  (clk_0),
      .i_rst  (rst),
      .i_raw  (w_raw[g]),
      .o_level(w_lvl[g])
    );
  end

  // Delayed debounced levels for press (1->0) detection.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) r_lvl_q <= '1;
    else     r_lvl_q <= w_lvl;
  end

  assign w_press = r_lvl_q & ~w_lvl;
  assign w_menu  = game_startup | game_over;

  // Delayed menu flag so PLAY reacts to a new menu entry, not to the flag
  // the game logic keeps high for a cycle after our pulse.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) r_menu_q <= 1'b0;
    else     r_menu_q <= w_menu;
  end

  // Menu FSM with registered start pulse and mode choice.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      r_state <= ST_ARMING;
      r_start <= 1'b0;
      r_mode  <= MODE_NONE;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_ARMING: begin
          // Wait until every button is released so a held button cannot
          // count as a fresh press on the new screen.
          if (w_menu && (&w_lvl)) r_state <= ST_READY;
        end
        ST_READY: begin
          if (game_startup) begin
            if (w_press[0]) begin
              r_mode  <= MODE_1P;
              r_start <= 1'b1;
              r_state <= ST_PLAY;
            end else if (w_press[1]) begin
              r_mode  <= MODE_2P;
              r_start <= 1'b1;
              r_state <= ST_PLAY;
            end
          end else if (game_over && (|w_press)) begin
            r_start <= 1'b1;
            r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (w_menu && !r_menu_q) r_state <= ST_ARMING;
        end
        default: r_state <= ST_ARMING;
      endcase
    end
  end

  assign up_p1         = w_lvl[0];
  assign down_p1       = w_lvl[1];
  assign up_p2         = w_lvl[2];
  assign down_p2       = w_lvl[3];
  assign start_trigger = r_start;
  assign mode_choice   = r_mode;

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Directed bench for pong_input_ctrl with a 4-cycle debounce window.
module tb_pong_input_ctrl;

  logic       clk_0 = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] raw   = 4'hF;   // {down_p2, up_p2, down_p1, up_p1}
  logic       gs    = 1'b0;
  logic       go    = 1'b0;

  logic       up_p1, down_p1, up_p2, down_p2, start_trigger;
  logic [1:0] mode_choice;
  logic [3:0] btn;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_0 = ~clk_0;

  pong_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .up_p1_raw    (raw[0]),
    .down_p1_raw  (raw[1]),
    .up_p2_raw    (raw[2]),
    .down_p2_raw  (raw[3]),
    .game_startup (gs),
    .game_over    (go),
    .up_p1        (up_p1),
    .down_p1      (down_p1),
    .up_p2        (up_p2),
    .down_p2      (down_p2),
    .start_trigger(start_trigger),
    .mode_choice  (mode_choice)
  );

  assign btn = {down_p2, up_p2, down_p1, up_p1};

  typedef struct {
    logic [3:0] raw;
    logic       gs;
    logic       go;
    int         n;
    logic [3:0] e_btn;
    logic       e_trig;
    logic [1:0] e_mode;
  } vec_t;

  vec_t tbl[30];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  initial begin
    // raw, gs, go, cycles, exp btn, exp trig, exp mode
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 2,  4'hF, 1'b0, 2'd0}; // arm on start menu
    tbl[1]  = '{4'hB, 1'b1, 1'b0, 5,  4'hF, 1'b0, 2'd0}; // up_p2 press, not yet debounced
    tbl[2]  = '{4'hB, 1'b1, 1'b0, 1,  4'hB, 1'b0, 2'd0};
    tbl[3]  = '{4'hB, 1'b1, 1'b0, 1,  4'hB, 1'b0, 2'd0}; // P2 ignored on menu
    tbl[4]  = '{4'hB, 1'b1, 1'b0, 3,  4'hB, 1'b0, 2'd0};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 6,  4'hF, 1'b0, 2'd0};
    tbl[6]  = '{4'hD, 1'b1, 1'b0, 6,  4'hD, 1'b0, 2'd0}; // down_p1 press
    tbl[7]  = '{4'hD, 1'b1, 1'b0, 1,  4'hD, 1'b1, 2'd2}; // 7 cycles after raw edge
    tbl[8]  = '{4'hD, 1'b1, 1'b0, 1,  4'hD, 1'b0, 2'd2}; // flag still high
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 6,  4'hF, 1'b0, 2'd2};
    tbl[10] = '{4'hE, 1'b1, 1'b0, 6,  4'hE, 1'b0, 2'd2}; // press while in PLAY
    tbl[11] = '{4'hE, 1'b1, 1'b0, 1,  4'hE, 1'b0, 2'd2};
    tbl[12] = '{4'hF, 1'b0, 1'b0, 6,  4'hF, 1'b0, 2'd2};
    tbl[13] = '{4'hF, 1'b1, 1'b0, 2,  4'hF, 1'b0, 2'd2}; // new menu entry
    tbl[14] = '{4'hC, 1'b1, 1'b0, 6,  4'hC, 1'b0, 2'd2}; // up+down same cycle
    tbl[15] = '{4'hC, 1'b1, 1'b0, 1,  4'hC, 1'b1, 2'd1};
    tbl[16] = '{4'hC, 1'b1, 1'b0, 1,  4'hC, 1'b0, 2'd1};
    tbl[17] = '{4'hE, 1'b0, 1'b0, 6,  4'hE, 1'b0, 2'd1}; // keep up_p1 held
    tbl[18] = '{4'hE, 1'b0, 1'b1, 10, 4'hE, 1'b0, 2'd1}; // game over, blocked
    tbl[19] = '{4'hF, 1'b0, 1'b1, 6,  4'hF, 1'b0, 2'd1};
    tbl[20] = '{4'hF, 1'b0, 1'b1, 1,  4'hF, 1'b0, 2'd1};
    tbl[21] = '{4'h7, 1'b0, 1'b1, 6,  4'h7, 1'b0, 2'd1}; // down_p2 press
    tbl[22] = '{4'h7, 1'b0, 1'b1, 1,  4'h7, 1'b1, 2'd1};
    tbl[23] = '{4'h7, 1'b0, 1'b1, 1,  4'h7, 1'b0, 2'd1};
    tbl[24] = '{4'h7, 1'b0, 1'b0, 3,  4'h7, 1'b0, 2'd1};
    tbl[25] = '{4'hF, 1'b0, 1'b0, 6,  4'hF, 1'b0, 2'd1};
    tbl[26] = '{4'hF, 1'b0, 1'b1, 2,  4'hF, 1'b0, 2'd1}; // game_over rises again
    tbl[27] = '{4'hB, 1'b0, 1'b1, 6,  4'hB, 1'b0, 2'd1};
    tbl[28] = '{4'hB, 1'b0, 1'b1, 1,  4'hB, 1'b1, 2'd1};
    tbl[29] = '{4'hB, 1'b0, 1'b1, 1,  4'hB, 1'b0, 2'd1};

    // Power-on reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("por_btn", btn, 4'hF);
    chk("por_trig", start_trigger, 0);
    chk("por_mode", mode_choice, 0);

    // 3-cycle glitch on up_p2 must be rejected
    raw = 4'hB;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_hold", up_p2, 1);
    end
    raw = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch_after", up_p2, 1);
    end

    // Longer press lands exactly 6 cycles after the raw edge
    raw = 4'hB;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("press_early_c%0d", k), up_p2, 1);
    end
    tick();
    chk("press_c6", up_p2, 0);
    raw = 4'hF;
    repeat (6) tick();
    chk("release_c6", up_p2, 1);
    chk("glitch_mode", mode_choice, 0);

    // Table-driven menu scenarios
    for (int i = 0; i < 30; i++) begin
      raw = tbl[i].raw;
      gs  = tbl[i].gs;
      go  = tbl[i].go;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        if (k < tbl[i].n - 1) chk($sformatf("row%0d_trig_idle", i), start_trigger, 0);
      end
      chk($sformatf("row%0d_btn", i), btn, tbl[i].e_btn);
      chk($sformatf("row%0d_trig", i), start_trigger, tbl[i].e_trig);
      chk($sformatf("row%0d_mode", i), mode_choice, tbl[i].e_mode);
    end

    // Asynchronous reset mid-run with every button held
    raw = 4'h0;
    go  = 1'b0;
    repeat (6) tick();
    chk("pre_rst_btn", btn, 4'h0);
    #3 rst = 1'b1;
    #1;
    chk("rst_btn", btn, 4'hF);
    chk("rst_trig", start_trigger, 0);
    chk("rst_mode", mode_choice, 0);
    tick();
    rst = 1'b0;
    raw = 4'hF;
    gs  = 1'b1;
    repeat (2) tick();
    raw = 4'hE;
    repeat (6) tick();
    chk("post_rst_trig_idle", start_trigger, 0);
    tick();
    chk("post_rst_trig", start_trigger, 1);
    chk("post_rst_mode", mode_choice, 1);
    tick();
    chk("post_rst_trig_end", start_trigger, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
